// File: rtl/vreg_port_arbiter.sv
// Round-robin arbiter sharing the two ports of the vector register file among NUM_REQ requesters.
// Grants up to one request per port per cycle and never pairs conflicting accesses to one address.
module vreg_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 4,
   parameter int ID_WIDTH   = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [ADDR_WIDTH-1:0]            rf_addr_a,
   output logic [ADDR_WIDTH-1:0]            rf_addr_b,
   output logic                             rf_we_a,
   output logic                             rf_we_b,
   output logic [DATA_WIDTH-1:0]            rf_din_a,
   output logic [DATA_WIDTH-1:0]            rf_din_b,
   input  logic [DATA_WIDTH-1:0]            rf_dout_a,
   input  logic [DATA_WIDTH-1:0]            rf_dout_b,
   output logic                             rsp_valid_a,
   output logic                             rsp_valid_b,
   output logic [ID_WIDTH-1:0]              rsp_id_a,
   output logic [ID_WIDTH-1:0]              rsp_id_b,
   output logic [DATA_WIDTH-1:0]            rsp_data_a,
   output logic [DATA_WIDTH-1:0]            rsp_data_b
);

   typedef logic [ID_WIDTH-1:0] id_t;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

   id_t  rr_ptr;
   id_t  cand;
   id_t  idx_a;
   id_t  idx_b;
   logic grant_a;
   logic grant_b;
   logic rsp_valid_a_q;
   logic rsp_valid_b_q;

   // Modulo-NUM_REQ increment; base is always below NUM_REQ so one subtraction suffices.
   function automatic id_t wrap_add(input id_t base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return ID_WIDTH'(sum);
   endfunction

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      // NOTE: every signal gets a default before the scan so no path leaves it unassigned (no latch).
      grant_a = 1'b0;
      grant_b = 1'b0;
      idx_a   = '0;
      idx_b   = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrap_add(rr_ptr, k);
         if (!rst && req_valid[cand]) begin
            if (!grant_a) begin
               grant_a = 1'b1;
               idx_a   = cand;
            end else if (!grant_b &&
                         !((addr_arr[cand] == addr_arr[idx_a]) && (req_we[cand] || req_we[idx_a]))) begin
               grant_b = 1'b1;
               idx_b   = cand;
            end
         end
      end
   end

   // Idle ports present we=0 and addr=0; the register file writes on any edge with we=1.
   always_comb begin
      req_ready = '0;
      if (grant_a) req_ready[idx_a] = 1'b1;
      if (grant_b) req_ready[idx_b] = 1'b1;
      rf_we_a   = grant_a & req_we[idx_a];
      rf_we_b   = grant_b & req_we[idx_b];
      rf_addr_a = grant_a ? addr_arr[idx_a]  : '0;
      rf_addr_b = grant_b ? addr_arr[idx_b]  : '0;
      rf_din_a  = grant_a ? wdata_arr[idx_a] : '0;
      rf_din_b  = grant_b ? wdata_arr[idx_b] : '0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         rr_ptr        <= '0;
         rsp_valid_a_q <= 1'b0;
         rsp_valid_b_q <= 1'b0;
         rsp_id_a      <= '0;
         rsp_id_b      <= '0;
      end else begin
         if (grant_b)      rr_ptr <= wrap_add(idx_b, 1);
         else if (grant_a) rr_ptr <= wrap_add(idx_a, 1);
         rsp_valid_a_q <= grant_a & ~req_we[idx_a];
         rsp_valid_b_q <= grant_b & ~req_we[idx_b];
         if (grant_a) rsp_id_a <= idx_a;
         if (grant_b) rsp_id_b <= idx_b;
      end
   end

   // A read granted just before reset must never surface, so reset also masks the pending response.
   assign rsp_valid_a = rsp_valid_a_q & ~rst;
   assign rsp_valid_b = rsp_valid_b_q & ~rst;
   assign rsp_data_a  = rf_dout_a;
   assign rsp_data_b  = rf_dout_b;

endmodule

// File: tb/tb_vreg_port_arbiter.sv
// Directed bench for vreg_port_arbiter with a behavioural 16x128b dual-port register file.
// Each task drives one scenario and checks the hand-computed grants, ports and responses.
module tb_vreg_port_arbiter;

   localparam int N  = 4;
   localparam int DW = 128;
   localparam int AW = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            rf_init = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_we = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    req_ready;
   logic [AW-1:0]   rf_addr_a, rf_addr_b;
   logic            rf_we_a, rf_we_b;
   logic [DW-1:0]   rf_din_a, rf_din_b;
   logic [DW-1:0]   rf_dout_a, rf_dout_b;
   logic            rsp_valid_a, rsp_valid_b;
   logic [IW-1:0]   rsp_id_a, rsp_id_b;
   logic [DW-1:0]   rsp_data_a, rsp_data_b;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem [16];

   localparam logic [DW-1:0] DATA_A5 = {16{8'hA5}};
   localparam logic [DW-1:0] DATA_3C = {16{8'h3C}};
   localparam logic [DW-1:0] DATA_X  = {8{16'h1111}};
   localparam logic [DW-1:0] DATA_Y  = {8{16'h2222}};

   always #5 clk = ~clk;

   vreg_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready),
      .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
      .rf_we_a(rf_we_a), .rf_we_b(rf_we_b),
      .rf_din_a(rf_din_a), .rf_din_b(rf_din_b),
      .rf_dout_a(rf_dout_a), .rf_dout_b(rf_dout_b),
      .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b),
      .rsp_id_a(rsp_id_a), .rsp_id_b(rsp_id_b),
      .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b)
   );

   function automatic logic [DW-1:0] init_val(input int i);
      return {16{8'(8'h30 + i)}};
   endfunction

   // Register file: synchronous write, registered read.
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      end else begin
         if (rf_we_a) mem[rf_addr_a] <= rf_din_a;
         if (rf_we_b) mem[rf_addr_b] <= rf_din_b;
      end
      rf_dout_a <= mem[rf_addr_a];
      rf_dout_b <= mem[rf_addr_b];
   end

   task automatic clear_reqs();
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      req_valid[i]           = 1'b1;
      req_we[i]              = we;
      req_addr[i*AW +: AW]   = addr;
      req_wdata[i*DW +: DW]  = data;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), '1);
      tick();
      tick();
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      checks++; if (rf_we_a !== 1'b0 || rf_we_b !== 1'b0) begin errors++; $display("FAIL reset_we: got %b%b expected 00", rf_we_a, rf_we_b); end
      rst = 1'b0;
      rf_init = 1'b0;
      clear_reqs();
      #1;
      checks++; if (rsp_valid_a !== 1'b0 || rsp_valid_b !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b%b expected 00", rsp_valid_a, rsp_valid_b); end
      checks++; if (rsp_id_a !== 2'd0 || rsp_id_b !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d,%0d expected 0,0", rsp_id_a, rsp_id_b); end
      checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr); end
   endtask

   task automatic test_write_then_read();
      set_req(0, 1'b1, 4'd3, DATA_A5);
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wr_ready: got %b expected 0001", req_ready); end
      checks++; if (rf_we_a !== 1'b1 || rf_addr_a !== 4'd3 || rf_din_a !== DATA_A5) begin errors++; $display("FAIL wr_port_a: we=%b addr=%0d din=%h expected we=1 addr=3 din=%h", rf_we_a, rf_addr_a, rf_din_a, DATA_A5); end
      checks++; if (rf_we_b !== 1'b0 || rf_addr_b !== 4'd0) begin errors++; $display("FAIL wr_port_b_idle: we=%b addr=%0d expected we=0 addr=0", rf_we_b, rf_addr_b); end
      tick();
      checks++; if (rsp_valid_a !== 1'b0 || rsp_valid_b !== 1'b0) begin errors++; $display("FAIL wr_no_rsp: got %b%b expected 00", rsp_valid_a, rsp_valid_b); end
      checks++; if (dut.rr_ptr !== 2'd1) begin errors++; $display("FAIL wr_rr_ptr: got %0d expected 1", dut.rr_ptr); end
      clear_reqs();
      set_req(1, 1'b0, 4'd3, '0);
      #1;
      checks++; if (req_ready !== 4'b0010 || rf_we_a !== 1'b0 || rf_addr_a !== 4'd3) begin errors++; $display("FAIL rd_grant: ready=%b we_a=%b addr_a=%0d expected 0010,0,3", req_ready, rf_we_a, rf_addr_a); end
      tick();
      clear_reqs();
      checks++; if (rsp_valid_a !== 1'b1 || rsp_id_a !== 2'd1 || rsp_valid_b !== 1'b0) begin errors++; $display("FAIL rd_rsp: valid_a=%b id_a=%0d valid_b=%b expected 1,1,0", rsp_valid_a, rsp_id_a, rsp_valid_b); end
      checks++; if (rsp_data_a !== DATA_A5) begin errors++; $display("FAIL rd_data: got %h expected %h", rsp_data_a, DATA_A5); end
      checks++; if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL rd_rr_ptr: got %0d expected 2", dut.rr_ptr); end
   endtask

   task automatic test_single_requester();
      set_req(3, 1'b0, 4'd0, '0);
      #1;
      checks++; if (req_ready !== 4'b1000 || rf_addr_a !== 4'd0) begin errors++; $display("FAIL single_grant: ready=%b addr_a=%0d expected 1000,0", req_ready, rf_addr_a); end
      checks++; if (rf_we_b !== 1'b0 || rf_addr_b !== 4'd0) begin errors++; $display("FAIL single_b_idle: we=%b addr=%0d expected 0,0", rf_we_b, rf_addr_b); end
      tick();
      clear_reqs();
      checks++; if (rsp_valid_a !== 1'b1 || rsp_id_a !== 2'd3 || rsp_data_a !== init_val(0) || rsp_valid_b !== 1'b0) begin errors++; $display("FAIL single_rsp: valid=%b id=%0d data=%h valid_b=%b expected 1,3,%h,0", rsp_valid_a, rsp_id_a, rsp_data_a, rsp_valid_b, init_val(0)); end
      checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL single_rr_ptr: got %0d expected 0", dut.rr_ptr); end
   endtask

   task automatic test_dual_read();
      set_req(0, 1'b0, 4'd2, '0);
      set_req(2, 1'b0, 4'd5, '0);
      #1;
      checks++; if (req_ready !== 4'b0101 || rf_addr_a !== 4'd2 || rf_addr_b !== 4'd5) begin errors++; $display("FAIL dual_grant: ready=%b addr_a=%0d addr_b=%0d expected 0101,2,5", req_ready, rf_addr_a, rf_addr_b); end
      tick();
      clear_reqs();
      checks++; if (rsp_valid_a !== 1'b1 || rsp_valid_b !== 1'b1 || rsp_id_a !== 2'd0 || rsp_id_b !== 2'd2) begin errors++; $display("FAIL dual_rsp: valid=%b%b ids=%0d,%0d expected 11, 0,2", rsp_valid_a, rsp_valid_b, rsp_id_a, rsp_id_b); end
      checks++; if (rsp_data_a !== init_val(2) || rsp_data_b !== init_val(5)) begin errors++; $display("FAIL dual_data: got %h / %h expected %h / %h", rsp_data_a, rsp_data_b, init_val(2), init_val(5)); end
      checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL dual_rr_ptr: got %0d expected 3", dut.rr_ptr); end
   endtask

   task automatic test_conflict();
      // Move the pointer from 3 to 1 with a lone grant to requester 0.
      set_req(0, 1'b0, 4'd4, '0);
      tick();
      clear_reqs();
      checks++; if (dut.rr_ptr !== 2'd1) begin errors++; $display("FAIL conf_setup_rr_ptr: got %0d expected 1", dut.rr_ptr); end
      set_req(1, 1'b1, 4'd7, DATA_3C);
      set_req(2, 1'b0, 4'd7, '0);
      #1;
      checks++; if (req_ready !== 4'b0010 || rf_we_a !== 1'b1 || rf_addr_a !== 4'd7 || rf_we_b !== 1'b0) begin errors++; $display("FAIL conf_first: ready=%b we_a=%b addr_a=%0d we_b=%b expected 0010,1,7,0", req_ready, rf_we_a, rf_addr_a, rf_we_b); end
      tick();
      req_valid[1] = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0100 || rf_we_a !== 1'b0 || rf_addr_a !== 4'd7) begin errors++; $display("FAIL conf_second: ready=%b we_a=%b addr_a=%0d expected 0100,0,7", req_ready, rf_we_a, rf_addr_a); end
      tick();
      clear_reqs();
      checks++; if (rsp_valid_a !== 1'b1 || rsp_id_a !== 2'd2 || rsp_data_a !== DATA_3C) begin errors++; $display("FAIL conf_rsp: valid=%b id=%0d data=%h expected 1,2,%h", rsp_valid_a, rsp_id_a, rsp_data_a, DATA_3C); end
      checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL conf_rr_ptr: got %0d expected 3", dut.rr_ptr); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_ready;
      logic [IW-1:0] exp_a, exp_b, exp_rr;
      set_req(3, 1'b0, 4'd0, '0);
      tick();
      clear_reqs();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(10 + i), '0);
      for (int c = 0; c < 4; c++) begin
         exp_ready = (c % 2 == 0) ? 4'b0011 : 4'b1100;
         exp_a     = (c % 2 == 0) ? 2'd0 : 2'd2;
         exp_b     = (c % 2 == 0) ? 2'd1 : 2'd3;
         exp_rr    = (c % 2 == 0) ? 2'd2 : 2'd0;
         #1;
         checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, exp_ready); end
         tick();
         checks++; if (rsp_valid_a !== 1'b1 || rsp_valid_b !== 1'b1 || rsp_id_a !== exp_a || rsp_id_b !== exp_b) begin errors++; $display("FAIL rr_rsp[%0d]: valid=%b%b ids=%0d,%0d expected 11, %0d,%0d", c, rsp_valid_a, rsp_valid_b, rsp_id_a, rsp_id_b, exp_a, exp_b); end
         checks++; if (rsp_data_a !== init_val(10 + int'(exp_a)) || rsp_data_b !== init_val(10 + int'(exp_b))) begin errors++; $display("FAIL rr_data[%0d]: got %h / %h", c, rsp_data_a, rsp_data_b); end
         checks++; if (dut.rr_ptr !== exp_rr) begin errors++; $display("FAIL rr_ptr[%0d]: got %0d expected %0d", c, dut.rr_ptr, exp_rr); end
      end
      clear_reqs();
   endtask

   task automatic test_reset_drop();
      set_req(2, 1'b0, 4'd1, '0);
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL drop_grant: got %b expected 0100", req_ready); end
      tick();
      rst = 1'b1;
      clear_reqs();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), '1);
      #1;
      checks++; if (rsp_valid_a !== 1'b0 || rsp_valid_b !== 1'b0) begin errors++; $display("FAIL drop_rsp_masked: got %b%b expected 00", rsp_valid_a, rsp_valid_b); end
      checks++; if (req_ready !== 4'b0000 || rf_we_a !== 1'b0 || rf_we_b !== 1'b0) begin errors++; $display("FAIL drop_in_reset: ready=%b we=%b%b expected 0000,00", req_ready, rf_we_a, rf_we_b); end
      tick();
      checks++; if (rsp_valid_a !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL drop_held: valid_a=%b ready=%b expected 0,0000", rsp_valid_a, req_ready); end
      rst = 1'b0;
      clear_reqs();
      #1;
      checks++; if (rsp_valid_a !== 1'b0 || dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL drop_after: valid_a=%b rr_ptr=%0d expected 0,0", rsp_valid_a, dut.rr_ptr); end
   endtask

   task automatic test_write_write();
      set_req(0, 1'b1, 4'd9, DATA_X);
      set_req(3, 1'b1, 4'd9, DATA_Y);
      #1;
      checks++; if (req_ready !== 4'b0001 || rf_we_b !== 1'b0) begin errors++; $display("FAIL ww_first: ready=%b we_b=%b expected 0001,0", req_ready, rf_we_b); end
      tick();
      req_valid[0] = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b1000 || rf_we_a !== 1'b1 || rf_din_a !== DATA_Y) begin errors++; $display("FAIL ww_second: ready=%b we_a=%b din_a=%h expected 1000,1,%h", req_ready, rf_we_a, rf_din_a, DATA_Y); end
      tick();
      clear_reqs();
      set_req(1, 1'b0, 4'd9, '0);
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ww_read_grant: got %b expected 0010", req_ready); end
      tick();
      clear_reqs();
      checks++; if (rsp_valid_a !== 1'b1 || rsp_id_a !== 2'd1 || rsp_data_a !== DATA_Y) begin errors++; $display("FAIL ww_final: valid=%b id=%0d data=%h expected 1,1,%h", rsp_valid_a, rsp_id_a, rsp_data_a, DATA_Y); end
      checks++; if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL ww_rr_ptr: got %0d expected 2", dut.rr_ptr); end
   endtask

   task automatic test_read_read_same();
      // Pointer is 2: requester 2 wins A, the scan wraps past 3 and 0 to give requester 1 port B.
      set_req(1, 1'b0, 4'd1, '0);
      set_req(2, 1'b0, 4'd1, '0);
      #1;
      checks++; if (req_ready !== 4'b0110 || rf_addr_a !== 4'd1 || rf_addr_b !== 4'd1) begin errors++; $display("FAIL rr_same_grant: ready=%b addr=%0d,%0d expected 0110,1,1", req_ready, rf_addr_a, rf_addr_b); end
      tick();
      clear_reqs();
      checks++; if (rsp_id_a !== 2'd2 || rsp_id_b !== 2'd1 || rsp_valid_a !== 1'b1 || rsp_valid_b !== 1'b1) begin errors++; $display("FAIL rr_same_ids: valid=%b%b ids=%0d,%0d expected 11, 2,1", rsp_valid_a, rsp_valid_b, rsp_id_a, rsp_id_b); end
      checks++; if (rsp_data_a !== init_val(1) || rsp_data_b !== init_val(1)) begin errors++; $display("FAIL rr_same_data: got %h / %h expected %h", rsp_data_a, rsp_data_b, init_val(1)); end
      checks++; if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL rr_same_rr_ptr: got %0d expected 2", dut.rr_ptr); end
   endtask

   initial begin
      test_reset();
      test_write_then_read();
      test_single_requester();
      test_dual_read();
      test_conflict();
      test_round_robin();
      test_reset_drop();
      test_write_write();
      test_read_read_same();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
